// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-step logic/arith ops,
// bit-serial shifts and a 32-iteration shift-add multiplier.
module alu_exec_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  ALUCtl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result,
  output logic        zero,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  op_q, op_n;
  logic [31:0] a_q, a_n;
  logic [31:0] b_q, b_n;
  logic [31:0] acc_q, acc_n;
  logic [5:0]  cnt_q, cnt_n;

  logic        fin;
  logic        fin_ill;
  logic [31:0] fin_val;

  logic        is_shift;
  logic        is_mul;
  logic        legal;
  logic [31:0] simple;

  assign is_shift = (ALUCtl == 4'd3) ||
                    (ALUCtl == 4'd4) ||
                    (ALUCtl == 4'd5);
  assign is_mul   = (ALUCtl == 4'd8);

  always_comb begin
    simple = '0;
    legal  = 1'b1;
    case (ALUCtl)
      4'd0:  simple = op_a & op_b;
      4'd1:  simple = op_a | op_b;
      4'd2:  simple = op_a + op_b;
      4'd6:  simple = op_a - op_b;
      4'd7:  simple = {31'd0,
                       $signed(op_a) < $signed(op_b)};
      4'd12: simple = ~(op_a | op_b);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    fin     = 1'b0;
    fin_ill = 1'b0;
    fin_val = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          op_n  = ALUCtl;
          a_n   = op_a;
          b_n   = op_b;
          acc_n = '0;
          cnt_n = '0;
          unique case (1'b1)
            is_shift: begin
              cnt_n = {1'b0, op_b[4:0]};
              if (op_b[4:0] == 5'd0) begin
                state_n = DONE;
                fin     = 1'b1;
                fin_val = op_a;
              end else begin
                state_n = SHIFT;
              end
            end
            is_mul: begin
              cnt_n   = 6'd32;
              state_n = MUL;
            end
            default: begin
              state_n = DONE;
              fin     = 1'b1;
              fin_val = simple;
              fin_ill = !legal;
            end
          endcase
        end
      end
      SHIFT: begin
        // SLL/SRL shift in zero; SRA keeps the sign bit
        case (op_q)
          4'd3:    a_n = {a_q[30:0], 1'b0};
          4'd4:    a_n = {1'b0, a_q[31:1]};
          default: a_n = {a_q[31], a_q[31:1]};
        endcase
        cnt_n = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_n = DONE;
          fin     = 1'b1;
          fin_val = a_n;
        end
      end
      MUL: begin
        acc_n = acc_q + (b_q[0] ? a_q : 32'd0);
        a_n   = {a_q[30:0], 1'b0};
        b_n   = {1'b0, b_q[31:1]};
        cnt_n = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_n = DONE;
          fin     = 1'b1;
          fin_val = acc_n;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
      acc_q <= acc_n;
      cnt_q <= cnt_n;
      if (fin) begin
        result  <= fin_val;
        zero    <= (fin_val == 32'd0);
        illegal <= fin_ill;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
// Inputs driven and outputs sampled on the falling edge.
module tb_alu_exec_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  ALUCtl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .ALUCtl  (ALUCtl),
    .op_a    (op_a),
    .op_b    (op_b),
    .result  (result),
    .zero    (zero),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [7:0]  l;
  } vec_t;

  // Pulses start for one cycle, scrambles the inputs afterwards,
  // and waits for done; lat counts cycles after the accepting edge.
  task automatic run_op(input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int lat);
    @(negedge clock);
    start  = 1'b1;
    ALUCtl = c;
    op_a   = a;
    op_b   = b;
    @(negedge clock);
    start  = 1'b0;
    ALUCtl = ~c;
    op_a   = ~a;
    op_b   = ~b;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    ALUCtl = '0;
    op_a = '0;
    op_b = '0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: res=%h z=%b b=%b d=%b i=%b want 0 1 0 0 0",
               result, zero, busy, done, illegal);
    end
    reset = 1'b0;
  endtask

  task automatic test_ops;
    vec_t v[14];
    int lat;
    v[0]  = '{c:4'd2,  a:32'hFFFF_FFFF, b:32'd1,
              r:32'd0, l:8'd1};
    v[1]  = '{c:4'd7,  a:32'hFFFF_FFFE, b:32'd3,
              r:32'd1, l:8'd1};
    v[2]  = '{c:4'd7,  a:32'd3, b:32'hFFFF_FFFE,
              r:32'd0, l:8'd1};
    v[3]  = '{c:4'd0,  a:32'hF0F0_F0F0, b:32'hFF00_FF00,
              r:32'hF000_F000, l:8'd1};
    v[4]  = '{c:4'd1,  a:32'h0F0F_0000, b:32'h0000_00F0,
              r:32'h0F0F_00F0, l:8'd1};
    v[5]  = '{c:4'd12, a:32'd0, b:32'd0,
              r:32'hFFFF_FFFF, l:8'd1};
    v[6]  = '{c:4'd6,  a:32'd5, b:32'd7,
              r:32'hFFFF_FFFE, l:8'd1};
    v[7]  = '{c:4'd5,  a:32'h8000_0000, b:32'd4,
              r:32'hF800_0000, l:8'd5};
    v[8]  = '{c:4'd5,  a:32'h8000_0000, b:32'd0,
              r:32'h8000_0000, l:8'd1};
    v[9]  = '{c:4'd4,  a:32'h8000_0000, b:32'd4,
              r:32'h0800_0000, l:8'd5};
    v[10] = '{c:4'd3,  a:32'd1, b:32'd31,
              r:32'h8000_0000, l:8'd32};
    v[11] = '{c:4'd3,  a:32'd3, b:32'h0000_0021,
              r:32'd6, l:8'd2};
    v[12] = '{c:4'd8,  a:32'h0001_0001, b:32'h0001_0001,
              r:32'h0002_0001, l:8'd33};
    v[13] = '{c:4'd8,  a:32'hFFFF_FFFF, b:32'hFFFF_FFFF,
              r:32'd1, l:8'd33};
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].c, v[i].a, v[i].b, lat);
      n_checks++;
      if (lat !== int'(v[i].l)) begin
        n_fail++;
        $display("FAIL op%0d latency: got %0d want %0d",
                 i, lat, v[i].l);
      end
      n_checks++;
      if (result !== v[i].r || zero !== (v[i].r == 32'd0) ||
          illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL op%0d value: res=%h z=%b i=%b want %h %b 0",
                 i, result, zero, illegal, v[i].r,
                 v[i].r == 32'd0);
      end
    end
  endtask

  task automatic test_busy_drop;
    int bad = 0;
    @(negedge clock);
    start  = 1'b1;
    ALUCtl = 4'd8;
    op_a   = 32'h0001_0001;
    op_b   = 32'h0001_0001;
    @(negedge clock);
    start  = 1'b0;
    ALUCtl = 4'd2;
    op_a   = 32'd9;
    op_b   = 32'd9;
    for (int k = 1; k <= 32; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      start = (k % 5 == 0);
      @(negedge clock);
    end
    start = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mul_busy: %0d bad cycles want 0", bad);
    end
    n_checks++;
    if (done !== 1'b1 || result !== 32'h0002_0001) begin
      n_fail++;
      $display("FAIL mul_done: d=%b res=%h want 1 00020001",
               done, result);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL drop1: b=%b d=%b want 0 0", busy, done);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || result !== 32'h0002_0001) begin
      n_fail++;
      $display("FAIL drop2: b=%b res=%h want 0 00020001",
               busy, result);
    end
  endtask

  task automatic test_illegal;
    int lat;
    run_op(4'd9, 32'd5, 32'd5, lat);
    n_checks++;
    if (lat != 1 || result !== 32'd0 || zero !== 1'b1 ||
        illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL undef: lat=%0d res=%h z=%b i=%b want 1 0 1 1",
               lat, result, zero, illegal);
    end
    run_op(4'd2, 32'd1, 32'd1, lat);
    n_checks++;
    if (lat != 1 || result !== 32'd2 || zero !== 1'b0 ||
        illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL after_undef: lat=%0d res=%h z=%b i=%b want 1 2 0 0",
               lat, result, zero, illegal);
    end
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    @(negedge clock);
    start  = 1'b1;
    ALUCtl = 4'd2;
    op_a   = 32'd20;
    op_b   = 32'd22;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (done !== (k % 2 == 1)) bad++;
      if (busy !== (k % 2 == 1)) bad++;
    end
    start = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b pattern: %0d bad samples want 0", bad);
    end
    n_checks++;
    if (result !== 32'd42) begin
      n_fail++;
      $display("FAIL b2b result: got %h want 0000002a", result);
    end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset_mid_mul;
    int pulses = 0;
    @(negedge clock);
    start  = 1'b1;
    ALUCtl = 4'd8;
    op_a   = 32'd3;
    op_b   = 32'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 ||
        zero !== 1'b1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: b=%b d=%b res=%h z=%b i=%b want 0 0 0 1 0",
               busy, done, result, zero, illegal);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset: activity=%0d res=%h want 0 0",
               pulses, result);
    end
  endtask

  initial begin
    test_reset;
    test_ops;
    test_busy_drop;
    test_illegal;
    test_back_to_back;
    test_reset_mid_mul;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 SHALL have port: start  input  1  request to execute one operation; sampled only when busy=0.
REQ-004 SHALL have port: ALUCtl  input  4  operation code from the ALU control decoder.
REQ-005 SHALL have port: op_a  input  32  first operand.
REQ-006 SHALL have port: op_b  input  32  second operand; op_b[4:0] is shift amount for shifts.
REQ-007 SHALL have port: result  output  32  registered result of last completed operation.
REQ-008 SHALL have port: zero  output  1  registered; 1 when result==0.
REQ-009 SHALL have port: busy  output  1  1 while an operation is in progress (start ignored).
REQ-010 SHALL have port: done  output  1  one-cycle pulse when result/zero become valid.
REQ-011 SHALL have port: illegal  output  1  registered; 1 when last accepted ALUCtl was undefined.

Function
REQ-012 SHALL decode ALUCtl: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SRA, 6 SUB, 7 SLT (signed), 8 MUL (low 32 bits, unsigned shift-add), 12 NOR; all other codes undefined.
REQ-013 SHALL implement FSM states IDLE, SHIFT, MUL, DONE; reset state IDLE.
REQ-014 SHALL accept start only in IDLE; on acceptance latch ALUCtl, op_a, op_b into internal registers; later input changes have no effect on the operation.
REQ-015 Single-step ops (0,1,2,6,7,12) and undefined codes SHALL go IDLE->DONE; done=1 in cycle N+1 for start sampled at edge N.
REQ-016 Shifts SHALL load op_a and counter=op_b[4:0]; shamt=0 goes IDLE->DONE (latency 1); otherwise IDLE->SHIFT, one bit per cycle, counter decrements, SHIFT->DONE when counter reaches 0; done at cycle N+1+shamt.
REQ-017 SRA SHALL replicate bit 31 on each step; SRL and SLL SHALL insert 0.
REQ-018 MUL SHALL use 6-bit iteration counter, 32 iterations in MUL state (multiplicand shifted left, multiplier shifted right, accumulate when multiplier LSB=1); done at cycle N+33; upper product bits discarded.
REQ-019 ADD/SUB SHALL wrap modulo 2^32; no overflow flag.
REQ-020 SLT SHALL produce 32'd1 if signed op_a < signed op_b else 32'd0.
REQ-021 Undefined ALUCtl SHALL produce result=0, zero=1, illegal=1; defined codes SHALL clear illegal at completion.
REQ-022 DONE SHALL last exactly one cycle then return to IDLE; busy=1 in SHIFT, MUL, DONE and in the cycle after acceptance; busy=0 only in IDLE.
REQ-023 result, zero, illegal SHALL update only on the DONE-entry edge and hold until next completion.
REQ-024 start asserted while busy=1 SHALL be dropped, not queued.
REQ-025 start held high continuously SHALL launch a new operation on each return to IDLE (back-to-back spacing latency+1 cycles).

Reset
REQ-026 On reset=1 at a clock edge: state=IDLE, result=0, zero=1, busy=0, done=0, illegal=0, counters and latched operands cleared.
REQ-027 Reset SHALL take priority over start and abort any in-progress SHIFT/MUL with no done pulse and no result update.
REQ-028 Outputs before the first reset edge are undefined; bench SHALL assert reset at least one cycle.

Verification
REQ-029 ADD: ALUCtl=2, op_a=32'hFFFF_FFFF, op_b=1, start 1 cycle -> one cycle later done=1, result=0, zero=1, illegal=0.
REQ-030 SLT: ALUCtl=7, op_a=32'hFFFF_FFFE (-2), op_b=3 -> result=1, zero=0, done at latency 1.
REQ-031 SRA: ALUCtl=5, op_a=32'h8000_0000, op_b=4 -> busy 5 cycles, done at N+5, result=32'hF800_0000; repeat with op_b=0 -> done at N+1, result=32'h8000_0000.
REQ-032 MUL: ALUCtl=8, op_a=32'h0001_0001, op_b=32'h0001_0001 -> done exactly at N+33, result=32'h0002_0001; start pulses during busy ignored.
REQ-033 Undefined: ALUCtl=9, op_a=5, op_b=5 -> done at N+1, result=0, zero=1, illegal=1; next ADD 1+1 -> result=2, illegal=0.
REQ-034 Reset mid-MUL: assert reset at cycle N+10 -> next cycle busy=0, done=0, result=0, zero=1; no done pulse follows.
